// File: rtl/alu_arbiter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | alu_arbiter_pkg : ALU opcodes, arbiter FSM encodings, grant helper          |
// | Revision        : 1.0                                                       |
// +-----------------------------------------------------------------------------+
package alu_arbiter_pkg;

   localparam int ALU_W = 32;

   typedef logic [2:0] alu_op_t;

   localparam alu_op_t ALU_ADD = 3'd0;
   localparam alu_op_t ALU_SUB = 3'd1;
   localparam alu_op_t ALU_AND = 3'd2;
   localparam alu_op_t ALU_OR  = 3'd3;
   localparam alu_op_t ALU_SRL = 3'd4;
   localparam alu_op_t ALU_SRA = 3'd5;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   // Round-robin pick: a lone requester always wins, a tie goes to the one not served last.
   function automatic logic pick_grant(input logic v0, input logic v1, input logic last_grant);
      if (v0 && v1) begin
         return ~last_grant;
      end
      return v0 ? 1'b0 : 1'b1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | alu_arbiter_alu : combinational ALU shared by both arbiter requesters       |
// | Revision        : 1.0                                                       |
// +-----------------------------------------------------------------------------+
module alu_arbiter_alu
   import alu_arbiter_pkg::*;
#(
   parameter int WIDTH = ALU_W
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  alu_op_t          alu_op,
   output logic [WIDTH-1:0] c
);

   localparam int SH_W = $clog2(WIDTH);

   logic             b_big;
   logic [SH_W-1:0]  shamt;
   logic [WIDTH-1:0] srl_res;
   logic [WIDTH-1:0] sra_res;

   // The whole of B is the shift amount, so any bit above the index range saturates.
   assign b_big = |b[WIDTH-1:SH_W];
   assign shamt = b[SH_W-1:0];

   assign srl_res = b_big ? '0 : (a >> shamt);
   assign sra_res = b_big ? {WIDTH{a[WIDTH-1]}} : $unsigned($signed(a) >>> shamt);

   always_comb begin
      c = sra_res;
      case (alu_op)
         ALU_ADD: c = a + b;
         ALU_SUB: c = a - b;
         ALU_AND: c = a & b;
         ALU_OR:  c = a | b;
         ALU_SRL: c = srl_res;
         default: c = sra_res;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | alu_arbiter : round-robin share of one ALU between two valid/ready clients  |
// | Revision    : 1.0                                                           |
// +-----------------------------------------------------------------------------+
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int WIDTH = ALU_W,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [2:0]       req0_op,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [WIDTH-1:0] rsp0_data,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [2:0]       req1_op,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp1_data,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);

   logic [1:0]       state_q,      state_d;
   logic             owner_q,      owner_d;
   logic             last_grant_q, last_grant_d;
   logic [WIDTH-1:0] a_q,          a_d;
   logic [WIDTH-1:0] b_q,          b_d;
   alu_op_t          op_q,         op_d;
   logic [WIDTH-1:0] res_q,        res_d;
   logic [CNT_W-1:0] cnt_q,        cnt_d;

   logic             is_idle;
   logic             grant;
   logic             accept;
   logic             rsp_hs;
   logic [WIDTH-1:0] alu_c;

   alu_arbiter_alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .a      (a_q),
      .b      (b_q),
      .alu_op (op_q),
      .c      (alu_c)
   );

   assign is_idle = (state_q == S_IDLE);
   assign grant   = pick_grant(req0_valid, req1_valid, last_grant_q);

   assign req0_ready = is_idle && req0_valid && (grant == 1'b0);
   assign req1_ready = is_idle && req1_valid && (grant == 1'b1);
   assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

   assign rsp0_valid = (state_q == S_RESP) && (owner_q == 1'b0);
   assign rsp1_valid = (state_q == S_RESP) && (owner_q == 1'b1);
   assign rsp0_data  = res_q;
   assign rsp1_data  = res_q;
   assign rsp_hs     = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

   assign busy     = !is_idle;
   assign op_count = cnt_q;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      a_d          = a_q;
      b_d          = b_q;
      op_d         = op_q;
      res_d        = res_q;
      cnt_d        = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               owner_d      = grant;
               last_grant_d = grant;
               a_d          = grant ? req1_a  : req0_a;
               b_d          = grant ? req1_b  : req0_b;
               op_d         = grant ? req1_op : req0_op;
               state_d      = S_EXEC;
            end
         end
         S_EXEC: begin
            res_d   = alu_c;
            state_d = S_RESP;
         end
         S_RESP: begin
            // Returning to IDLE first means a request seen alongside this handshake waits a cycle.
            if (rsp_hs) begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= ALU_ADD;
         res_q        <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         a_q          <= a_d;
         b_q          <= b_d;
         op_q         <= op_d;
         res_q        <= res_d;
         cnt_q        <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------------+
// | tb_alu_arbiter : directed stimulus checked against a transaction model      |
// | Revision       : 1.0                                                        |
// +-----------------------------------------------------------------------------+
module tb_alu_arbiter;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [2:0]  req0_op = '0, req1_op = '0;
   logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
   logic [31:0] rsp0_data, rsp1_data;
   logic [15:0] op_count;

   alu_arbiter #(.WIDTH(32), .CNT_W(16)) u_dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_op(req0_op), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_op(req1_op), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
      .busy(busy), .op_count(op_count)
   );

   // Narrow-counter instance so the counter wrap is reached in a few operations.
   logic        s_v = 1'b0, s_zero = 1'b0, s_one = 1'b1;
   logic [31:0] s_a = 32'd1, s_b = 32'd2;
   logic [2:0]  s_op = 3'd0;
   logic        s_r0, s_r1, s_rv0, s_rv1, s_busy;
   logic [31:0] s_d0, s_d1;
   logic [1:0]  s_count;

   alu_arbiter #(.WIDTH(32), .CNT_W(2)) u_dut_wrap (
      .clk(clk), .reset(reset),
      .req0_valid(s_v), .req0_ready(s_r0), .req0_a(s_a), .req0_b(s_b),
      .req0_op(s_op), .rsp0_valid(s_rv0), .rsp0_ready(s_one), .rsp0_data(s_d0),
      .req1_valid(s_zero), .req1_ready(s_r1), .req1_a(s_a), .req1_b(s_b),
      .req1_op(s_op), .rsp1_valid(s_rv1), .rsp1_ready(s_one), .rsp1_data(s_d1),
      .busy(s_busy), .op_count(s_count)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] op);
      longint unsigned ua, ub;
      longint sa, q, d;
      ua = 64'(a);
      ub = 64'(b);
      case (op)
         3'd0: return 32'((ua + ub) % 64'h1_0000_0000);
         3'd1: return 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return (ub >= 64'd32) ? 32'd0 : 32'(ua / (64'd1 << ub));
         default: begin
            if (ub >= 64'd32) return a[31] ? 32'hFFFF_FFFF : 32'd0;
            sa = a[31] ? (longint'(ua) - 64'sh1_0000_0000) : longint'(ua);
            d  = longint'(64'd1 << ub);
            q  = sa / d;
            if ((sa < 0) && (q * d != sa)) q = q - 1;
            return 32'(q);
         end
      endcase
   endfunction

   // Transaction model: at most one op in flight, response two cycles after acceptance.
   logic        m_busy, m_owner, m_last, win, exp_v0, exp_v1, exp_r0, exp_r1;
   logic [31:0] m_data;
   logic [15:0] m_count;
   int          m_acc_cyc;

   always @(negedge clk) begin
      if (reset) begin
         m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_data = '0; m_count = '0; m_acc_cyc = 0;
      end else begin
         exp_v0 = m_busy && !m_owner && (cyc >= m_acc_cyc + 2);
         exp_v1 = m_busy &&  m_owner && (cyc >= m_acc_cyc + 2);
         win    = (req0_valid && req1_valid) ? !m_last : !req0_valid;
         exp_r0 = !m_busy && req0_valid && !win;
         exp_r1 = !m_busy && req1_valid && win;
         check("mdl_req0_ready", req0_ready, exp_r0);
         check("mdl_req1_ready", req1_ready, exp_r1);
         check("mdl_rsp0_valid", rsp0_valid, exp_v0);
         check("mdl_rsp1_valid", rsp1_valid, exp_v1);
         check("mdl_busy", busy, m_busy);
         check("mdl_op_count", op_count, m_count);
         if (exp_v0) check("mdl_rsp0_data", rsp0_data, m_data);
         if (exp_v1) check("mdl_rsp1_data", rsp1_data, m_data);
         if ((exp_v0 && rsp0_ready) || (exp_v1 && rsp1_ready)) begin
            m_busy  = 1'b0;
            m_count = m_count + 16'd1;
         end else if (exp_r0 || exp_r1) begin
            m_busy    = 1'b1;
            m_owner   = win;
            m_last    = win;
            m_acc_cyc = cyc;
            m_data    = win ? model_alu(req1_a, req1_b, req1_op) : model_alu(req0_a, req0_b, req0_op);
         end
      end
   end

   logic [1:0] s_exp;
   logic       s_wrapped;
   always @(negedge clk) begin
      if (reset) begin
         s_exp = 2'd0; s_wrapped = 1'b0;
      end else begin
         check("wrap_op_count", s_count, s_exp);
         if (s_rv0) begin
            s_exp = s_exp + 2'd1;
            if (s_exp == 2'd0) s_wrapped = 1'b1;
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 30) begin @(negedge clk); n++; end
      check("idle_reached", busy, 1'b0);
      @(posedge clk); #1;
   endtask

   task automatic run_op(input bit idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, output logic [31:0] res);
      int n = 0;
      if (idx) begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; rsp1_ready = 1; end
      else     begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; rsp0_ready = 1; end
      @(negedge clk);
      while (!(idx ? req1_ready : req0_ready) && n < 20) begin @(negedge clk); n++; end
      check("op_accepted", idx ? req1_ready : req0_ready, 1'b1);
      @(posedge clk); #1;
      if (idx) req1_valid = 0; else req0_valid = 0;
      n = 0;
      @(negedge clk);
      while (!(idx ? rsp1_valid : rsp0_valid) && n < 20) begin @(negedge clk); n++; end
      check("op_responded", idx ? rsp1_valid : rsp0_valid, 1'b1);
      res = idx ? rsp1_data : rsp0_data;
      @(posedge clk); #1;
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1; reset = 1;
      @(posedge clk); #1; reset = 0;
   endtask

   logic [31:0] t3_b   [6] = '{32'd4, 32'd4, 32'd4, 32'd40, 32'd40, 32'd31};
   logic [2:0]  t3_op  [6] = '{3'd5, 3'd4, 3'd7, 3'd4, 3'd6, 3'd4};
   logic [31:0] t3_exp [6] = '{32'hF800_0000, 32'h0800_0000, 32'hF800_0000,
                               32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001};

   initial begin
      logic [31:0] r;
      int g[4];
      int ng, n;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_rsp0_valid", rsp0_valid, 0);
      check("rst_rsp1_valid", rsp1_valid, 0);
      check("rst_rsp0_data", rsp0_data, 0);
      check("rst_op_count", op_count, 0);
      check("rst_busy", busy, 0);
      @(posedge clk); #1; reset = 0; s_v = 1;

      // Single add: accepted immediately, result two cycles later.
      req0_valid = 1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 3'd0; rsp0_ready = 1;
      @(negedge clk); check("t1_req0_ready", req0_ready, 1);
      @(posedge clk); #1; req0_valid = 0;
      @(negedge clk); check("t1_rsp0_valid_exec", rsp0_valid, 0);
      @(negedge clk); check("t1_rsp0_valid", rsp0_valid, 1); check("t1_rsp0_data", rsp0_data, 32'd8);
      @(posedge clk); #1;
      @(negedge clk); check("t1_op_count", op_count, 1); check("t1_busy", busy, 0);
      @(posedge clk); #1;

      // Both requesters held valid: grants alternate starting with requester 0.
      pulse_reset();
      req0_valid = 1; req0_a = 32'd3; req0_b = 32'd5; req0_op = 3'd1;
      req1_valid = 1; req1_a = 32'd3; req1_b = 32'd5; req1_op = 3'd1;
      rsp0_ready = 1; rsp1_ready = 1;
      g = '{2, 2, 2, 2}; ng = 0; n = 0;
      while (ng < 4 && n < 60) begin
         @(negedge clk); n++;
         if (rsp0_valid) check("t2_rsp0_data", rsp0_data, 32'hFFFF_FFFE);
         if (rsp1_valid) check("t2_rsp1_data", rsp1_data, 32'hFFFF_FFFE);
         if (req0_ready) begin g[ng] = 0; ng++; end
         else if (req1_ready) begin g[ng] = 1; ng++; end
         @(posedge clk); #1;
         if (ng == 4) begin req0_valid = 0; req1_valid = 0; end
      end
      req0_valid = 0; req1_valid = 0;
      for (int i = 0; i < 4; i++) check($sformatf("t2_grant%0d", i), g[i], i % 2);
      wait_idle();

      // Shift corner cases with a negative operand.
      for (int i = 0; i < 6; i++) begin
         run_op(1'b0, 32'h8000_0000, t3_b[i], t3_op[i], r);
         check($sformatf("t3_shift%0d", i), r, t3_exp[i]);
      end

      // Back-pressure: result held, other requester kept waiting.
      rsp0_ready = 0;
      req0_valid = 1; req0_a = 32'h1234_5678; req0_b = 32'h1111_1111; req0_op = 3'd0;
      @(negedge clk); check("t4_req0_ready", req0_ready, 1);
      @(posedge clk); #1;
      req0_valid = 0; req1_valid = 1; req1_a = 32'd7; req1_b = 32'd1; req1_op = 3'd1; rsp1_ready = 1;
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t4_rsp0_valid", rsp0_valid, 1);
         check("t4_rsp0_data", rsp0_data, 32'h2345_6789);
         check("t4_req1_ready", req1_ready, 0);
         check("t4_busy", busy, 1);
         @(posedge clk); #1;
      end
      rsp0_ready = 1;
      @(negedge clk); check("t4_req1_ready_hs", req1_ready, 0);
      @(posedge clk); #1;
      @(negedge clk); check("t4_idle_after", busy, 0); check("t4_req1_ready_idle", req1_ready, 1);
      @(posedge clk); #1; req1_valid = 0;
      wait_idle();

      // Asynchronous reset during EXEC discards the operation.
      req0_valid = 1; req0_a = 32'd1; req0_b = 32'd2; req0_op = 3'd0; rsp0_ready = 1;
      @(negedge clk); check("t5_req0_ready", req0_ready, 1);
      @(posedge clk); #2;
      check("t5_busy_exec", busy, 1);
      reset = 1; req0_valid = 0; #1;
      check("t5_rst_busy", busy, 0);
      check("t5_rst_rsp0_valid", rsp0_valid, 0);
      check("t5_rst_rsp0_data", rsp0_data, 0);
      check("t5_rst_op_count", op_count, 0);
      @(posedge clk); #1; reset = 0;
      run_op(1'b1, 32'h0F0F_0000, 32'h00FF_00FF, 3'd3, r);
      check("t5_or_result", r, 32'h0FFF_00FF);

      // Counter wrap on the narrow instance.
      n = 0;
      while (!s_wrapped && n < 100) begin @(negedge clk); n++; end
      check("t6_wrap_seen", s_wrapped, 1);
      @(negedge clk); check("t6_count_after_wrap", s_count, 2'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
